// File: rtl/sccb_master.sv
// sccb_master: single-transaction SCCB (OV7670) register master.
// Optional read path is enabled with `define SCCB_READ_EN.
module sccb_master #(
  parameter int         CLK_F    = 27_000_000,
  parameter int         I2C_F    = 400_000,
  parameter logic [7:0] DEV_ADDR = 8'h42
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_start,
  input  logic [7:0] i_reg_addr,
  input  logic [7:0] i_reg_data,
`ifdef SCCB_READ_EN
  input  logic       i_rw,
  input  logic       i_siod,
  output logic       o_siod_oe,
  output logic [7:0] o_rd_data,
`endif
  output logic       o_ready,
  output logic       o_done,
  output logic       o_sioc,
  output logic       o_siod
);

  localparam int DIV = CLK_F / (4 * I2C_F);
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] TOP = CW'(DIV - 1);

  generate
    if (DIV < 1) begin : g_div_chk
      $error("sccb_master: CLK_F/(4*I2C_F) must be at least 1");
    end
  endgenerate

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_BITS  = 3'd2;
  localparam logic [2:0] S_STOP  = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]    state, n_state;
  logic [1:0]    q, n_q;
  logic [CW-1:0] cnt;
  logic [4:0]    bidx, n_bidx;
  logic [4:0]    last;
  logic [26:0]   sh;
  logic          ph2, n_ph2;
  logic          rd, rd_req;
  logic          tick, adv, accept;
  logic          nbit, n_sioc, n_siod;

`ifdef SCCB_READ_EN
  assign rd_req = i_rw;
`else
  assign rd_req = 1'b0;
`endif

  assign tick   = (cnt == TOP);
  assign accept = (state == S_IDLE) && i_start;

  // Next position in the frame: state, quarter and bit index.
  always_comb begin
    n_state = state;
    n_q     = q;
    n_bidx  = bidx;
    n_ph2   = ph2;
    adv     = 1'b0;
    case (state)
      S_IDLE: begin
        if (i_start) begin
          adv     = 1'b1;
          n_state = S_START;
          n_q     = 2'd0;
          n_bidx  = 5'd0;
          n_ph2   = 1'b0;
        end
      end
      S_START, S_BITS, S_STOP: begin
        if (tick) begin
          adv = 1'b1;
          n_q = q + 2'd1;
          if (q == 2'd3) begin
            case (state)
              S_START: begin
                n_state = S_BITS;
                n_bidx  = 5'd0;
              end
              S_BITS: begin
                if (bidx == last) n_state = S_STOP;
                else n_bidx = bidx + 5'd1;
              end
              default: begin
                if (rd && !ph2) begin
                  n_state = S_START;
                  n_ph2   = 1'b1;
                end else begin
                  n_state = S_DONE;
                end
              end
            endcase
          end
        end
      end
      S_DONE: begin
        adv     = 1'b1;
        n_state = S_IDLE;
      end
      default: begin
        adv     = 1'b1;
        n_state = S_IDLE;
      end
    endcase
  end

  // Pin levels for the quarter about to begin.
  always_comb begin
    nbit   = (state == S_BITS) ? sh[25] : sh[26];
    n_sioc = o_sioc;
    n_siod = o_siod;
    case (n_state)
      S_START: begin
        case (n_q)
          2'd0: begin
            n_sioc = 1'b1;
            n_siod = 1'b1;
          end
          2'd1: n_siod = 1'b0;
          2'd2: n_sioc = 1'b0;
          default: ;
        endcase
      end
      S_BITS: begin
        case (n_q)
          2'd0: begin
            n_sioc = 1'b0;
            n_siod = nbit;
          end
          2'd1: n_sioc = 1'b1;
          2'd2: n_sioc = 1'b1;
          default: n_sioc = 1'b0;
        endcase
      end
      S_STOP: begin
        case (n_q)
          2'd0: begin
            n_sioc = 1'b0;
            n_siod = 1'b0;
          end
          2'd1: n_sioc = 1'b1;
          2'd2: n_siod = 1'b1;
          default: ;
        endcase
      end
      default: begin
        n_sioc = 1'b1;
        n_siod = 1'b1;
      end
    endcase
  end

  // Sequencer, quarter timer, frame shifter and bus pins.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state   <= S_IDLE;
      q       <= 2'd0;
      cnt     <= '0;
      bidx    <= 5'd0;
      last    <= 5'd0;
      sh      <= '0;
      ph2     <= 1'b0;
      rd      <= 1'b0;
      o_ready <= 1'b1;
      o_done  <= 1'b0;
      o_sioc  <= 1'b1;
      o_siod  <= 1'b1;
    end else begin
      state   <= n_state;
      q       <= n_q;
      bidx    <= n_bidx;
      ph2     <= n_ph2;
      o_ready <= (n_state == S_IDLE);
      o_done  <= (n_state == S_DONE);
      if (adv) begin
        o_sioc <= n_sioc;
        o_siod <= n_siod;
      end
      if (state == S_START || state == S_BITS || state == S_STOP)
        cnt <= tick ? '0 : cnt + CW'(1);
      else
        cnt <= '0;
      if (accept) begin
        rd <= rd_req;
        if (rd_req) begin
          sh   <= {DEV_ADDR, 1'b1, i_reg_addr, 1'b1, 9'h1FF};
          last <= 5'd17;
        end else begin
          sh   <= {DEV_ADDR, 1'b1, i_reg_addr, 1'b1,
                   i_reg_data, 1'b1};
          last <= 5'd26;
        end
      end else if (state == S_STOP && n_state == S_START) begin
        sh <= {DEV_ADDR | 8'h01, 1'b1, 8'hFF, 1'b1, 9'h1FF};
      end else if (state == S_BITS && tick && q == 2'd3) begin
        sh <= {sh[25:0], 1'b1};
      end
    end
  end

`ifdef SCCB_READ_EN
  logic [7:0] rd_sh;
  logic       n_oe;
  logic       rd_win;

  assign rd_win = ph2 && bidx >= 5'd9 && bidx <= 5'd16;
  assign n_oe   = !(n_state == S_BITS && n_ph2 &&
                    n_bidx >= 5'd9 && n_bidx <= 5'd16);

  // Release the line for the data byte and capture it.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_siod_oe <= 1'b1;
      o_rd_data <= 8'h00;
      rd_sh     <= 8'h00;
    end else begin
      if (adv) o_siod_oe <= n_oe;
      if (state == S_BITS && rd_win && q == 2'd2 && tick)
        rd_sh <= {rd_sh[6:0], i_siod};
      if (n_state == S_DONE && state != S_DONE && rd)
        o_rd_data <= rd_sh;
    end
  end
`endif

endmodule

// File: tb/tb_sccb_master.sv
// tb_sccb_master: directed + randomized checks of sccb_master
// against a frame/latency reference model.
module tb_sccb_master;

  localparam int         DIV0 = 27_000_000 / (4 * 400_000);
  localparam int         DIV1 = 1_600_000 / (4 * 400_000);
  localparam logic [7:0] DEV  = 8'h42;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       start0, start1;
  logic [7:0] a0, d0, a1, d1;
  logic       rdy0, dn0, scl0, sda0;
  logic       rdy1, dn1, scl1, sda1;
`ifdef SCCB_READ_EN
  logic       rw0, rw1, isd0, isd1, oe0, oe1;
  logic [7:0] rdd0, rdd1;
`endif

  sccb_master dut0 (
    .i_clk(clk), .i_rst(rst), .i_start(start0),
    .i_reg_addr(a0), .i_reg_data(d0),
`ifdef SCCB_READ_EN
    .i_rw(rw0), .i_siod(isd0),
    .o_siod_oe(oe0), .o_rd_data(rdd0),
`endif
    .o_ready(rdy0), .o_done(dn0),
    .o_sioc(scl0), .o_siod(sda0)
  );

  sccb_master #(.CLK_F(1_600_000), .I2C_F(400_000)) dut1 (
    .i_clk(clk), .i_rst(rst), .i_start(start1),
    .i_reg_addr(a1), .i_reg_data(d1),
`ifdef SCCB_READ_EN
    .i_rw(rw1), .i_siod(isd1),
    .o_siod_oe(oe1), .o_rd_data(rdd1),
`endif
    .o_ready(rdy1), .o_done(dn1),
    .o_sioc(scl1), .o_siod(sda1)
  );

  int ec = 0;
  always @(posedge clk) ec <= ec + 1;

  int n_pass = 0;
  int n_tot  = 0;
  int n_fail = 0;

  // Bus monitor: start/stop conditions and bits on SIOC rise.
  logic        ps[2] = '{1'b1, 1'b1};
  logic        pd[2] = '{1'b1, 1'b1};
  logic [63:0] mb[2] = '{64'd0, 64'd0};
  logic [63:0] fb[2] = '{64'd0, 64'd0};
  int          mc[2] = '{0, 0};
  int          fc[2] = '{0, 0};
  int          nst[2] = '{0, 0};
  int          nsp[2] = '{0, 0};
  int          ndone[2] = '{0, 0};
  int          novl = 0;
`ifdef SCCB_READ_EN
  int          rk = 0;
  int          oe_low = 0;
  logic [7:0]  rbyte = 8'h76;
`endif

  always @(negedge clk) begin
    logic [1:0] sc, sd, dn, ry;
    sc = {scl1, scl0};
    sd = {sda1, sda0};
    dn = {dn1, dn0};
    ry = {rdy1, rdy0};
`ifdef SCCB_READ_EN
    if (!oe0) oe_low++;
    if (oe0) rk = 0;
    else if (ps[0] && !scl0) rk++;
    isd0 = (rk < 8) ? rbyte[3'(7 - rk)] : 1'b1;
`endif
    for (int k = 0; k < 2; k++) begin
      if (ps[k] && sc[k] && pd[k] && !sd[k]) begin
        nst[k]++;
        mc[k] = 0;
        mb[k] = 64'd0;
      end else if (ps[k] && sc[k] && !pd[k] && sd[k]) begin
        nsp[k]++;
        fb[k] = mb[k];
        fc[k] = mc[k];
      end else if (!ps[k] && sc[k]) begin
        mb[k] = {mb[k][62:0], sd[k]};
        mc[k]++;
      end
      if (dn[k]) ndone[k]++;
      if (dn[k] && ry[k]) novl++;
      ps[k] = sc[k];
      pd[k] = sd[k];
    end
  end

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_tot++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Expected: ID,1,addr,1,data,1 then the STOP-phase SIOC rise at 0.
  task automatic chk_frame(input int k, input logic [7:0] a,
                           input logic [7:0] d,
                           input int st, input int sp);
    logic [27:0] e;
    e = {DEV, 1'b1, a, 1'b1, d, 1'b1, 1'b0};
    chk("frame_len", 64'(fc[k]), 64'd28);
    chk("frame_bits", {36'd0, fb[k][27:0]}, {36'd0, e});
    chk("frame_start", 64'(nst[k] - st), 64'd1);
    chk("frame_stop", 64'(nsp[k] - sp), 64'd1);
  endtask

  task automatic wr0(input logic [7:0] a, input logic [7:0] d,
                     output int acc, output int dn,
                     output bit to);
    int i;
    @(negedge clk);
    i = 0;
    while (!rdy0 && i < 5000) begin
      @(negedge clk);
      i++;
    end
    a0 = a;
    d0 = d;
    start0 = 1'b1;
    @(posedge clk);
    #1 acc = ec;
    @(negedge clk);
    start0 = 1'b0;
    a0 = 8'($urandom);
    d0 = 8'($urandom);
    i = 0;
    while (!dn0 && i < 5000) begin
      @(negedge clk);
      i++;
    end
    to = !dn0;
    dn = ec;
  endtask

  initial begin
    int acc, dn, st, sp, nd, idle, i;
    bit to;
    logic [7:0] ra, rd, r2;

    rst = 1'b1;
    start0 = 1'b0;
    start1 = 1'b0;
    a0 = 8'h00; d0 = 8'h00;
    a1 = 8'h00; d1 = 8'h00;
`ifdef SCCB_READ_EN
    rw0 = 1'b0; rw1 = 1'b0; isd1 = 1'b1;
`endif
    repeat (3) @(negedge clk);
    chk("rst_ready", 64'(rdy0), 64'd1);
    chk("rst_done", 64'(dn0), 64'd0);
    chk("rst_sioc", 64'(scl0), 64'd1);
    chk("rst_siod", 64'(sda0), 64'd1);
`ifdef SCCB_READ_EN
    chk("rst_oe", 64'(oe0), 64'd1);
    chk("rst_rd_data", 64'(rdd0), 64'd0);
`endif
    rst = 1'b0;

    st = nst[0]; sp = nsp[0];
    wr0(8'h12, 8'h80, acc, dn, to);
    chk("timeout_dflt", 64'(to), 64'd0);
    chk("done_lat_dflt", 64'(dn - acc + 1), 64'd1857);
    repeat (2) @(negedge clk);
    chk("ready_after", 64'(rdy0), 64'd1);
    chk_frame(0, 8'h12, 8'h80, st, sp);

    for (int t = 0; t < 3; t++) begin
      ra = 8'($urandom);
      rd = 8'($urandom);
      st = nst[0]; sp = nsp[0];
      wr0(ra, rd, acc, dn, to);
      chk("timeout_rand", 64'(to), 64'd0);
      chk("done_lat_rand", 64'(dn - acc), 64'(116 * DIV0));
      repeat (2) @(negedge clk);
      chk_frame(0, ra, rd, st, sp);
    end

    // Requests while busy are dropped.
    ra = 8'($urandom);
    rd = 8'($urandom);
    st = nst[0]; sp = nsp[0]; nd = ndone[0];
    @(negedge clk);
    a0 = ra; d0 = rd; start0 = 1'b1;
    @(posedge clk);
    #1 acc = ec;
    for (int c = 0; c < 116 * DIV0 - 20; c++) begin
      @(negedge clk);
      start0 = 1'($urandom);
      a0 = 8'($urandom);
      d0 = 8'($urandom);
    end
    @(negedge clk);
    start0 = 1'b0;
    i = 0;
    while (!dn0 && i < 100) begin
      @(negedge clk);
      i++;
    end
    dn = ec;
    chk("pulse_done_seen", 64'(dn0), 64'd1);
    chk("pulse_done_lat", 64'(dn - acc), 64'(116 * DIV0));
    repeat (50) @(negedge clk);
    chk("pulse_one_done", 64'(ndone[0] - nd), 64'd1);
    chk("pulse_ready", 64'(rdy0), 64'd1);
    chk_frame(0, ra, rd, st, sp);

    // Back-to-back with start held high.
    rd = 8'($urandom);
    r2 = 8'($urandom);
    st = nst[0]; sp = nsp[0]; nd = ndone[0];
    @(negedge clk);
    a0 = 8'h11; d0 = rd; start0 = 1'b1;
    @(posedge clk);
    #1 acc = ec;
    @(negedge clk);
    i = 0;
    while (!dn0 && i < 5000) begin
      @(negedge clk);
      i++;
    end
    dn = ec;
    chk("b2b_done1", 64'(dn0), 64'd1);
    chk("b2b_lat1", 64'(dn - acc), 64'(116 * DIV0));
    a0 = 8'h3A; d0 = r2;
    chk_frame(0, 8'h11, rd, st, sp);
    st = nst[0]; sp = nsp[0];
    idle = 0; i = 0;
    @(negedge clk);
    while (rdy0 && i < 10) begin
      idle++;
      @(negedge clk);
      i++;
    end
    acc = ec;
    start0 = 1'b0;
    chk("b2b_idle_cycles", 64'(idle), 64'd1);
    chk("b2b_gap", 64'(acc - dn), 64'd2);
    i = 0;
    while (!dn0 && i < 5000) begin
      @(negedge clk);
      i++;
    end
    dn = ec;
    chk("b2b_lat2", 64'(dn - acc), 64'(116 * DIV0));
    repeat (2) @(negedge clk);
    chk_frame(0, 8'h3A, r2, st, sp);
    chk("b2b_dones", 64'(ndone[0] - nd), 64'd2);

    // Reset in the middle of bit 10.
    @(negedge clk);
    a0 = 8'($urandom); d0 = 8'($urandom); start0 = 1'b1;
    @(posedge clk);
    #1 acc = ec;
    @(negedge clk);
    start0 = 1'b0;
    while (ec < acc + 44 * DIV0 + 3) @(negedge clk);
    chk("pre_rst_sioc", 64'(scl0), 64'd0);
    chk("pre_rst_ready", 64'(rdy0), 64'd0);
    nd = ndone[0];
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_sioc", 64'(scl0), 64'd1);
    chk("mid_rst_siod", 64'(sda0), 64'd1);
    chk("mid_rst_ready", 64'(rdy0), 64'd1);
    chk("mid_rst_done", 64'(dn0), 64'd0);
    repeat (2000) @(negedge clk);
    chk("mid_rst_no_done", 64'(ndone[0] - nd), 64'd0);
    ra = 8'($urandom);
    rd = 8'($urandom);
    st = nst[0]; sp = nsp[0];
    wr0(ra, rd, acc, dn, to);
    chk("timeout_post_rst", 64'(to), 64'd0);
    chk("done_lat_post_rst", 64'(dn - acc), 64'(116 * DIV0));
    repeat (2) @(negedge clk);
    chk_frame(0, ra, rd, st, sp);

    // Fastest divider.
    ra = 8'($urandom);
    rd = 8'($urandom);
    st = nst[1]; sp = nsp[1];
    @(negedge clk);
    chk("div1_ready", 64'(rdy1), 64'd1);
    a1 = ra; d1 = rd; start1 = 1'b1;
    @(posedge clk);
    #1 acc = ec;
    @(negedge clk);
    start1 = 1'b0;
    a1 = 8'($urandom);
    i = 0;
    while (!dn1 && i < 500) begin
      @(negedge clk);
      i++;
    end
    dn = ec;
    chk("div1_done_seen", 64'(dn1), 64'd1);
    chk("div1_lat", 64'(dn - acc + 1), 64'(116 * DIV1 + 1));
    repeat (2) @(negedge clk);
    chk_frame(1, ra, rd, st, sp);

`ifdef SCCB_READ_EN
    nd = oe_low;
    @(negedge clk);
    a0 = 8'h0A; rw0 = 1'b1; start0 = 1'b1;
    @(posedge clk);
    #1 acc = ec;
    @(negedge clk);
    start0 = 1'b0;
    rw0 = 1'b0;
    i = 0;
    while (!dn0 && i < 5000) begin
      @(negedge clk);
      i++;
    end
    dn = ec;
    chk("rd_lat", 64'(dn - acc), 64'(160 * DIV0));
    chk("rd_data", 64'(rdd0), 64'h76);
    chk("rd_oe_cycles", 64'(oe_low - nd), 64'(32 * DIV0));
    repeat (2) @(negedge clk);
    chk("rd_oe_idle", 64'(oe0), 64'd1);
`endif

    chk("ready_done_overlap", 64'(novl), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
